// File: rtl/stream_interpolator_if.sv
// Valid/ready sample stream in, filtered result stream out, for stream_interpolator.
interface stream_interpolator_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 18
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_phase;
    logic [1:0]        in_mode;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_phase, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_phase, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_interpolator.sv
// Pipelined 8-tap sub-sample interpolator (window -> L1 partials -> output).
// Define STREAM_INTERP_APPROX_EN to build the lower-bit-OR adder tree for mode 3.
module stream_interpolator #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 18,
    parameter int unsigned LOWER_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    stream_interpolator_if.slave  s
);
    localparam int unsigned TAPS = 8;
    localparam logic [1:0] PH_A        = 2'd0;
    localparam logic [1:0] PH_B        = 2'd1;
    localparam logic [1:0] PH_INT      = 2'd3;
    localparam logic [1:0] MODE_SIMPLE = 2'd1;
    localparam logic [1:0] MODE_SHORT  = 2'd2;
`ifdef STREAM_INTERP_APPROX_EN
    localparam logic [1:0] MODE_APPROX = 2'd3;
`endif

    if (ACC_W < DATA_W + 8) begin : g_bad_acc_w
        $error("stream_interpolator: ACC_W must be >= DATA_W+8");
    end
    if (LOWER_BITS < 1 || LOWER_BITS > ACC_W - 1) begin : g_bad_lower_bits
        $error("stream_interpolator: LOWER_BITS must be in 1..ACC_W-1");
    end

    logic              en, accept, issue;
    logic [3:0]        fill;
    logic [DATA_W-1:0] win [TAPS];
    logic              w_valid, w_last;
    logic [1:0]        w_phase, w_mode;
    logic [ACC_W-1:0]  p  [TAPS];
    logic [ACC_W-1:0]  l1 [4];
    logic [ACC_W-1:0]  s1 [4];
    logic              s1_valid, s1_last;
    logic [ACC_W-1:0]  l2a, l2b, sum;
`ifdef STREAM_INTERP_APPROX_EN
    logic              s1_apx;
`endif

    assign en         = ~s.out_valid | s.out_ready;
    assign s.in_ready = en & ~reset;
    assign accept     = s.in_valid & s.in_ready;
    assign issue      = accept & (fill >= 4'd7);

    // Coefficient for window tap k; tables are listed w7 -> w0, so tap k is entry ~k.
    function automatic logic signed [7:0] coef(input logic [1:0] ph, input logic [1:0] md,
                                               input logic [2:0] k);
        logic signed [7:0] t [TAPS];
        if (ph == PH_INT) begin
            t = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0};
        end else if (md == MODE_SIMPLE) begin
            case (ph)
                PH_A:    t = '{-8'sd1, 8'sd4, -8'sd8, 8'sd64, 8'sd16, -8'sd4, 8'sd1, 8'sd0};
                PH_B:    t = '{-8'sd1, 8'sd4, -8'sd8, 8'sd32, 8'sd32, -8'sd8, 8'sd4, -8'sd1};
                default: t = '{8'sd0, 8'sd1, -8'sd4, 8'sd16, 8'sd64, -8'sd8, 8'sd4, -8'sd1};
            endcase
        end else if (md == MODE_SHORT) begin
            case (ph)
                PH_A:    t = '{8'sd0, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd0, 8'sd0};
                PH_B:    t = '{8'sd0, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, 8'sd0};
                default: t = '{8'sd0, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, 8'sd0, 8'sd0};
            endcase
        end else begin
            case (ph)
                PH_A:    t = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
                PH_B:    t = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
                default: t = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
            endcase
        end
        return t[~k];
    endfunction

`ifdef STREAM_INTERP_APPROX_EN
    // Lower-bit-OR adder: low field ORed, upper field added with no carry-in.
    function automatic logic [ACC_W-1:0] tree_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                                  input logic apx);
        logic [ACC_W-1:0] r;
        r = a + b;
        if (apx) begin
            r[LOWER_BITS-1:0]     = a[LOWER_BITS-1:0] | b[LOWER_BITS-1:0];
            r[ACC_W-1:LOWER_BITS] = a[ACC_W-1:LOWER_BITS] + b[ACC_W-1:LOWER_BITS];
        end
        return r;
    endfunction
`endif

    // Products and first adder level from the window stage.
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            p[k] = ACC_W'($signed(ACC_W'(coef(w_phase, w_mode, 3'(k)))) * $signed(ACC_W'(win[k])));
        end
`ifdef STREAM_INTERP_APPROX_EN
        l1[0] = tree_add(p[7], p[6], w_mode == MODE_APPROX);
        l1[1] = tree_add(p[5], p[4], w_mode == MODE_APPROX);
        l1[2] = tree_add(p[3], p[2], w_mode == MODE_APPROX);
        l1[3] = tree_add(p[1], p[0], w_mode == MODE_APPROX);
`else
        l1[0] = p[7] + p[6];
        l1[1] = p[5] + p[4];
        l1[2] = p[3] + p[2];
        l1[3] = p[1] + p[0];
`endif
    end

    // Second and third adder levels from the L1 stage.
    always_comb begin
`ifdef STREAM_INTERP_APPROX_EN
        l2a = tree_add(s1[0], s1[1], s1_apx);
        l2b = tree_add(s1[2], s1[3], s1_apx);
        sum = tree_add(l2a, l2b, s1_apx);
`else
        l2a = s1[0] + s1[1];
        l2b = s1[2] + s1[3];
        sum = l2a + l2b;
`endif
    end

    // Window stage: shift on accept, fill counter saturates at 8 and clears on last.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill    <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            w_phase <= '0;
            w_mode  <= '0;
            for (int unsigned k = 0; k < TAPS; k++) win[k] <= '0;
        end else if (en) begin
            w_valid <= issue;
            if (accept) begin
                for (int unsigned k = TAPS - 1; k > 0; k--) win[k] <= win[k-1];
                win[0]  <= s.in_data;
                w_phase <= s.in_phase;
                w_mode  <= s.in_mode;
                w_last  <= s.in_last;
                if (s.in_last)         fill <= '0;
                else if (fill != 4'd8) fill <= fill + 4'd1;
            end
        end
    end

    // L1 partial-sum stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
`ifdef STREAM_INTERP_APPROX_EN
            s1_apx   <= 1'b0;
`endif
            for (int unsigned k = 0; k < 4; k++) s1[k] <= '0;
        end else if (en) begin
            s1_valid <= w_valid;
            s1_last  <= w_last;
`ifdef STREAM_INTERP_APPROX_EN
            s1_apx   <= (w_mode == MODE_APPROX);
`endif
            if (w_valid) begin
                for (int unsigned k = 0; k < 4; k++) s1[k] <= l1[k];
            end
        end
    end

    // Output stage; holds while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_last  <= 1'b0;
        end else if (en) begin
            s.out_valid <= s1_valid;
            s.out_last  <= s1_valid & s1_last;
            if (s1_valid) s.out_data <= sum;
        end
    end
endmodule

// File: doc/stream_interpolator.md
# stream_interpolator

Streaming 8-tap sub-sample interpolator: accepts one unsigned sample per cycle over a valid/ready handshake and keeps an 8-sample sliding window. Once the window is full, it emits one signed filtered value per accepted sample, for a per-sample fractional phase (quarter, half, three-quarter or integer). It is the parametrised, pipelined, back-pressured successor to the combinational A/B/C filter-value blocks. It also adds runtime-selectable coefficient modes (exact, simplified power-of-two, short-tap and lower-bit-OR approximate) and line flushing.

## Interface
- `DATA_W`, default 8: input sample width (unsigned).
- `ACC_W`, default 18: output and accumulator width (signed two's complement). Must be ≥ `DATA_W`+8; elaboration error otherwise.
- `LOWER_BITS`, default 4: low bits combined by OR (no carry) in approximate mode. Range 1..`ACC_W`-1.
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  sample present.
- `in_ready`  output  1  block can accept the sample.
- `in_data`  input  `DATA_W`  sample.
- `in_phase`  input  2  0=A (quarter), 1=B (half), 2=C (three-quarter), 3=integer.
- `in_mode`  input  2  0=exact, 1=simple, 2=short, 3=approx.
- `in_last`  input  1  final sample of a line.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  `ACC_W`  signed filter sum (unnormalised, gain 64 for exact mode).
- `out_last`  output  1  result belongs to the `in_last` sample.

## Operation
- A sample is accepted when `in_valid` and `in_ready` are both high. The window shifts: w[k]←w[k-1], w[0]←`in_data`.
- A fill counter (0..8) increments on each accept and saturates at 8.
- An accept that leaves the counter at 8 issues a result, computed with that sample's `in_phase` and `in_mode`. The first 7 samples of a line produce no output.
- `in_last` accepted: after that sample's result is issued (or immediately, if the line had fewer than 8 samples), the fill counter returns to 0. Window contents are don't-care after this.
- Product p[k] = coef[k]·w[k], with taps listed w7→w0. Absent taps are 0.
  - Exact: A = -1,4,-10,58,17,-5,1,0; B = -1,4,-11,40,40,-11,4,-1; C = 0,1,-5,17,58,-10,4,-1.
  - Simple: A = -1,4,-8,64,16,-4,1,0; B = -1,4,-8,32,32,-8,4,-1; C = 0,1,-4,16,64,-8,4,-1.
  - Short: A = 0,4,-10,58,17,-5,0,0; B = 0,4,-11,40,40,-11,4,0; C = 0,-5,17,58,-10,4,0,0.
  - Phase 3, any mode: output = w[3]·64.
- Fixed adder tree, all arithmetic modulo 2^`ACC_W`:
  - L1: p7+p6, p5+p4, p3+p2, p1+p0.
  - L2: (L1a+L1b), (L1c+L1d).
  - L3: L2a+L2b.
- Approx mode: every tree adder is a lower-bit adder. Low `LOWER_BITS` bits = A|B. Upper bits = A+B with no carry from the low field. Products use the exact coefficients.

## Timing
- Three pipeline registers: window (W), L1 partials (S1), output (OUT). Each has a valid bit.
- Global advance enable: `en` = !`out_valid` | `out_ready`. `in_ready` = `en`, and is 0 while `reset` is high.
- With no stall, latency is 2 cycles: sample accepted at edge N → S1 loaded at N+1 → `out_valid` high after edge N+2.
- Sustained throughput: 1 result per cycle.
- When `en` = 0, all stages hold. `out_data` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.
- Phase, mode and last travel with their sample through every stage. Changing `in_phase` or `in_mode` between samples is legal and takes effect per sample.
- Reset, asynchronous, at any time including mid-line or mid-stall clears:
  - fill counter, window and all valid bits;
  - `out_valid`, `out_data` and `out_last` to 0.
  - Results in flight are discarded.
- An output handshake and an input accept in the same cycle are both honoured.

## Configuration
- `STREAM_INTERP_APPROX_EN` defined: mode 3 uses the lower-bit-OR adder tree described above.
- Not defined: no approximate adder logic is built, and mode 3 behaves exactly as mode 0.

## Test plan
- Exact mode, constant `in_data`=100, phases A/B/C: no output for the first 7 samples, then `out_data`=6400 every cycle with `out_ready` held at 1.
- Constant 100, phase B: simple mode gives 5400; short mode gives 6600. Phase 3 gives 6400 in every mode.
- Approx mode (macro defined), `LOWER_BITS`=4, constant 1, phase A: `out_data`=31. Same stimulus without the macro gives 64.
- Hold `out_ready`=0 for 5 cycles with a result pending: `out_valid` stays 1, `out_data` is stable and `in_ready`=0. On release, results resume in order with none lost or duplicated.
- Nine-sample line with `in_last` on sample 9: exactly two outputs, the second with `out_last`=1. The next line's first output appears only after 8 new samples.
- Assert `reset` for one cycle mid-line with results in flight: outputs go to 0 immediately and no stale result appears afterwards. A fresh 8 samples are required before the next output.
